// File: rtl/atpg_fault_sequencer.sv
// atpg_fault_sequencer: stuck-at fault-injection campaign controller.
// Pass 0 runs fault-free. Passes 1..NUM_FAULTS each enable one inserted
// fault through a one-hot select. Every pass streams the full pattern set
// and compares the CUT response against the expected value.
// Optional feature macro: FAULT_DROP_EN. When defined, a faulty pass ends at
// its first detecting pattern. Pass 0 always runs the full set.
module atpg_fault_sequencer #(
    parameter int unsigned PI_W       = 7,
    parameter int unsigned PO_W       = 4,
    parameter int unsigned NUM_FAULTS = 3,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  ck_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pat_rewind_o,
    input  logic                  pat_valid_i,
    output logic                  pat_ready_o,
    input  logic [PI_W-1:0]       pat_data_i,
    input  logic [PO_W-1:0]       pat_exp_i,
    input  logic                  pat_last_i,
    output logic [PI_W-1:0]       cut_pi_o,
    input  logic [PO_W-1:0]       cut_po_i,
    output logic [NUM_FAULTS-1:0] fault_sel_o,
    output logic [NUM_FAULTS-1:0] det_mask_o,
    output logic                  golden_err_o,
    output logic [CNT_W-1:0]      pat_cnt_o,
    output logic [CNT_W-1:0]      fail_cnt_o
);

    localparam int unsigned PASS_W = $clog2(NUM_FAULTS + 1);
    localparam int unsigned SET_W  = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REWIND,
        S_FETCH,
        S_APPLY,
        S_CAPTURE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [PASS_W-1:0]       pass_q;
    logic [SET_W-1:0]        settle_q;
    logic [PO_W-1:0]         exp_q;
    logic                    last_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pat_rewind_q;
    logic                    pat_ready_q;
    logic [PI_W-1:0]         cut_pi_q;
    logic [NUM_FAULTS-1:0]   fault_sel_q;
    logic [NUM_FAULTS-1:0]   det_mask_q;
    logic                    golden_err_q;
    logic [CNT_W-1:0]        pat_cnt_q;
    logic [CNT_W-1:0]        fail_cnt_q;
    logic                    mismatch;

    // Compare the settled CUT response against the latched expectation.
    assign mismatch = (cut_po_i != exp_q);

    // Campaign FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pass_q       <= '0;
            settle_q     <= '0;
            exp_q        <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pat_rewind_q <= 1'b0;
            pat_ready_q  <= 1'b0;
            cut_pi_q     <= '0;
            fault_sel_q  <= '0;
            det_mask_q   <= '0;
            golden_err_q <= 1'b0;
            pat_cnt_q    <= '0;
            fail_cnt_q   <= '0;
        end else begin
            pat_rewind_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        det_mask_q   <= '0;
                        golden_err_q <= 1'b0;
                        pat_cnt_q    <= '0;
                        fail_cnt_q   <= '0;
                        pass_q       <= '0;
                        fault_sel_q  <= '0;
                        busy_q       <= 1'b1;
                        pat_rewind_q <= 1'b1;
                        state_q      <= S_REWIND;
                    end
                end
                S_REWIND: begin
                    pat_ready_q <= 1'b1;
                    state_q     <= S_FETCH;
                end
                S_FETCH: begin
                    if (pat_valid_i && pat_ready_q) begin
                        cut_pi_q    <= pat_data_i;
                        exp_q       <= pat_exp_i;
                        last_q      <= pat_last_i;
                        settle_q    <= SET_W'(SETTLE_CYC);
                        pat_ready_q <= 1'b0;
                        if (pat_cnt_q != {CNT_W{1'b1}}) begin
                            pat_cnt_q <= pat_cnt_q + CNT_W'(1);
                        end
                        state_q <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    settle_q <= settle_q - SET_W'(1);
                    if (settle_q == SET_W'(1)) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (mismatch) begin
                        if (fail_cnt_q != {CNT_W{1'b1}}) begin
                            fail_cnt_q <= fail_cnt_q + CNT_W'(1);
                        end
                        if (pass_q == PASS_W'(0)) begin
                            golden_err_q <= 1'b1;
                        end else begin
                            det_mask_q <= det_mask_q |
                                (NUM_FAULTS'(1) << (pass_q - PASS_W'(1)));
                        end
                    end
`ifdef FAULT_DROP_EN
                    if (last_q || (mismatch && (pass_q != PASS_W'(0)))) begin
`else
                    if (last_q) begin
`endif
                        state_q <= S_NEXT;
                    end else begin
                        pat_ready_q <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                S_NEXT: begin
                    if (pass_q == PASS_W'(NUM_FAULTS)) begin
                        done_q      <= 1'b1;
                        fault_sel_q <= '0;
                        state_q     <= S_DONE;
                    end else begin
                        pass_q       <= pass_q + PASS_W'(1);
                        fault_sel_q  <= NUM_FAULTS'(1) << pass_q;
                        pat_rewind_q <= 1'b1;
                        state_q      <= S_REWIND;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pat_rewind_o = pat_rewind_q;
    assign pat_ready_o  = pat_ready_q;
    assign cut_pi_o     = cut_pi_q;
    assign fault_sel_o  = fault_sel_q;
    assign det_mask_o   = det_mask_q;
    assign golden_err_o = golden_err_q;
    assign pat_cnt_o    = pat_cnt_q;
    assign fail_cnt_o   = fail_cnt_q;

endmodule
